dsc_mul_seq: RTL and testbench

Run sequencer for the 3-input, 10-bit deterministic stochastic multiplier (`dsc_mul`). It takes operand triplets over a valid/ready handshake and clears the multiplier before each run. It enables the multiplier and watches its early-shutoff flag `ov`, then captures the 30-bit product count and the elapsed run length into a result register. The result is presented downstream over a second valid/ready handshake.

---
 rtl/dsc_pkg.sv | 16 +
 rtl/dsc_mul_seq_if.sv | 49 ++++
 rtl/dsc_seq_ctr.sv | 37 +++
 rtl/dsc_mul_seq.sv | 145 ++++++++++++++
 tb/tb_dsc_mul_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and FSM state encoding for the dsc_mul run sequencer.
package dsc_pkg;

  localparam int unsigned SNG_WIDTH  = 10;
  localparam int unsigned NUM_INPUTS = 3;
  localparam int unsigned Z_WIDTH    = SNG_WIDTH * NUM_INPUTS;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StClear  = 3'd1;
  localparam state_t StRun    = 3'd2;
  localparam state_t StSettle = 3'd3;
  localparam state_t StDone   = 3'd4;

endpackage

// File: rtl/dsc_mul_seq_if.sv
// Operand, multiplier-control and result bundle between the sequencer and its neighbours.
interface dsc_mul_seq_if #(
    parameter int unsigned SNG_WIDTH  = dsc_pkg::SNG_WIDTH,
    parameter int unsigned NUM_INPUTS = dsc_pkg::NUM_INPUTS
);

    localparam int unsigned ZW = SNG_WIDTH * NUM_INPUTS;

    logic                 in_valid;
    logic                 in_ready;
    logic [SNG_WIDTH-1:0] in_a;
    logic [SNG_WIDTH-1:0] in_b;
    logic [SNG_WIDTH-1:0] in_c;

    logic [SNG_WIDTH-1:0] mul_a;
    logic [SNG_WIDTH-1:0] mul_b;
    logic [SNG_WIDTH-1:0] mul_c;
    logic                 mul_rst;
    logic                 mul_en;
    logic [ZW-1:0]        mul_z;
    logic                 mul_ov;

    logic                 res_valid;
    logic                 res_ready;
    logic [ZW-1:0]        res_z;
    logic [ZW-1:0]        res_cycles;
    logic                 res_timeout;

    // Environment side: operand source, multiplier and result sink.
    modport master (
        output in_valid, in_a, in_b, in_c,
        input  in_ready,
        input  mul_a, mul_b, mul_c, mul_rst, mul_en,
        output mul_z, mul_ov,
        input  res_valid, res_z, res_cycles, res_timeout,
        output res_ready
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, in_c,
        output in_ready,
        output mul_a, mul_b, mul_c, mul_rst, mul_en,
        input  mul_z, mul_ov,
        output res_valid, res_z, res_cycles, res_timeout,
        input  res_ready
    );

endinterface

// File: rtl/dsc_seq_ctr.sv
// Saturating up-counter with synchronous clear; tc_o flags the increment that lands on term_i.
module dsc_seq_ctr #(
    parameter int unsigned Width = 30
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Look ahead at the next value so the owner can leave its state on the terminal cycle.
    assign tc_o  = inc_i && !clr_i && (cnt_d == term_i);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dsc_mul_seq.sv
// Run sequencer for dsc_mul: accept operands, clear, run until ov or watchdog, present result.
module dsc_mul_seq #(
    parameter int unsigned SNG_WIDTH  = dsc_pkg::SNG_WIDTH,
    parameter int unsigned NUM_INPUTS = dsc_pkg::NUM_INPUTS,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 2 ** 30
) (
    input logic            clk_i,
    input logic            rst_ni,
    dsc_mul_seq_if.slave   bus
);

    import dsc_pkg::*;

    localparam int unsigned     ZW       = SNG_WIDTH * NUM_INPUTS;
    localparam longint unsigned ZMax     = (64'd1 << ZW) - 64'd1;
    // A cap beyond the counter range collapses to the saturation value so it can still fire.
    localparam longint unsigned RunTermL = (64'(MAX_CYCLES) > ZMax) ? ZMax : 64'(MAX_CYCLES);
    localparam logic [ZW-1:0]   RunTerm  = ZW'(RunTermL);
    localparam logic [ZW-1:0]   ClrTerm  = ZW'(CLR_CYCLES);

    // Asynchronous assert, two-flop synchronised release.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    state_t               state_q, state_d;
    logic [SNG_WIDTH-1:0] a_q, b_q, c_q;
    logic                 mul_rst_q, mul_en_q, res_valid_q;
    logic [ZW-1:0]        res_z_q, res_cycles_q;
    logic                 res_timeout_q, res_timeout_d;

    logic          accept;
    logic [ZW-1:0] clr_cnt, run_cnt;
    logic          clr_tc, run_tc;

    assign accept = (state_q == StIdle) && bus.in_valid;

    dsc_seq_ctr #(
        .Width (ZW)
    ) u_clr_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_n_int),
        .clr_i  (accept),
        .inc_i  (state_q == StClear),
        .term_i (ClrTerm),
        .cnt_o  (clr_cnt),
        .tc_o   (clr_tc)
    );

    dsc_seq_ctr #(
        .Width (ZW)
    ) u_run_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_n_int),
        .clr_i  (accept),
        .inc_i  (state_q == StRun),
        .term_i (RunTerm),
        .cnt_o  (run_cnt),
        .tc_o   (run_tc)
    );

    always_comb begin
        state_d       = state_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StClear;
            end
            StClear: begin
                if (clr_tc) state_d = StRun;
            end
            StRun: begin
                // Watchdog wins a tie; ov is only trusted once the first RUN cycle is past.
                if (run_tc) begin
                    state_d       = StSettle;
                    res_timeout_d = 1'b1;
                end else if ((run_cnt != '0) && bus.mul_ov) begin
                    state_d       = StSettle;
                    res_timeout_d = 1'b0;
                end
            end
            StSettle: begin
                state_d = StDone;
            end
            StDone: begin
                if (bus.res_ready) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q       <= StIdle;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            mul_rst_q     <= 1'b0;
            mul_en_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            res_z_q       <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_rst_q     <= (state_d == StClear);
            mul_en_q      <= (state_d == StRun) || (state_d == StSettle);
            res_valid_q   <= (state_d == StDone);
            res_timeout_q <= res_timeout_d;
            if (accept) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
                c_q <= bus.in_c;
            end
            if (state_q == StSettle) begin
                res_z_q      <= bus.mul_z;
                res_cycles_q <= run_cnt;
            end
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.mul_c       = c_q;
    assign bus.mul_rst     = mul_rst_q;
    assign bus.mul_en      = mul_en_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_z       = res_z_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq with a behavioural multiplier and a watchdog instance.
module tb_dsc_mul_seq;

    import dsc_pkg::*;

    localparam int unsigned ZW = Z_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dsc_mul_seq_if bus ();
    dsc_mul_seq_if wd ();

    dsc_mul_seq #(
        .CLR_CYCLES (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    dsc_mul_seq #(
        .CLR_CYCLES (2),
        .MAX_CYCLES (16)
    ) dut_wd (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (wd)
    );

    // Multiplier model: emits abc ones, z lags one cycle, ov once all ones are emitted.
    // Mode 2: z counts enabled cycles, ov pulses in the first RUN cycle and again at the sixth.
    int unsigned   mode = 0;
    logic [ZW-1:0] e_q, z_q, en_cnt_q, target;
    logic          bit_q;

    always_comb target = ZW'(bus.mul_a) * ZW'(bus.mul_b) * ZW'(bus.mul_c);

    always_ff @(posedge clk) begin
        if (bus.mul_rst) begin
            e_q      <= '0;
            bit_q    <= 1'b0;
            z_q      <= '0;
            en_cnt_q <= '0;
        end else if (bus.mul_en) begin
            if (e_q < target) begin
                e_q   <= e_q + ZW'(1);
                bit_q <= 1'b1;
            end else begin
                bit_q <= 1'b0;
            end
            z_q      <= z_q + ZW'(bit_q);
            en_cnt_q <= en_cnt_q + ZW'(1);
        end
    end

    always_comb begin
        bus.mul_z  = z_q;
        bus.mul_ov = (e_q == target);
        if (mode == 2) begin
            bus.mul_z  = en_cnt_q;
            bus.mul_ov = bus.mul_en && ((en_cnt_q == ZW'(0)) || (en_cnt_q == ZW'(5)));
        end
    end

    assign wd.mul_z  = ZW'(77);
    assign wd.mul_ov = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_main(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                            input logic [ZW-1:0] ez, input logic [ZW-1:0] ec,
                            input logic eto, input string nm);
        int guard;
        int lat;
        int nrst;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
        end
        check({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat  = 1;
        nrst = 0;
        while (!bus.res_valid && lat < 2000) begin
            if (bus.mul_rst) nrst++;
            step();
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'(ec) + 64'd4);
        check({nm, " mul_rst_cycles"}, 64'(nrst), 64'd2);
        check({nm, " res_z"}, 64'(bus.res_z), 64'(ez));
        check({nm, " res_cycles"}, 64'(bus.res_cycles), 64'(ec));
        check({nm, " res_timeout"}, 64'(bus.res_timeout), 64'(eto));
        check({nm, " mul_a_held"}, 64'(bus.mul_a), 64'(a));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check({nm, " res_valid_drop"}, 64'(bus.res_valid), 64'd0);
    endtask

    typedef struct {
        logic [9:0]    a;
        logic [9:0]    b;
        logic [9:0]    c;
        logic [ZW-1:0] z;
        logic [ZW-1:0] cyc;
        string         nm;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        vecs[0] = '{a: 10'd3,  b: 10'd5, c: 10'd7, z: 30'd105, cyc: 30'd106, nm: "p_3_5_7"};
        vecs[1] = '{a: 10'd4,  b: 10'd9, c: 10'd0, z: 30'd0,   cyc: 30'd2,   nm: "c_zero"};
        vecs[2] = '{a: 10'd1,  b: 10'd1, c: 10'd1, z: 30'd1,   cyc: 30'd2,   nm: "p_1_1_1"};
        vecs[3] = '{a: 10'd2,  b: 10'd2, c: 10'd2, z: 30'd8,   cyc: 30'd9,   nm: "p_2_2_2"};
        vecs[4] = '{a: 10'd10, b: 10'd1, c: 10'd3, z: 30'd30,  cyc: 30'd31,  nm: "p_10_1_3"};
        vecs[5] = '{a: 10'd0,  b: 10'd5, c: 10'd5, z: 30'd0,   cyc: 30'd2,   nm: "a_zero"};

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_c     = '0;
        bus.res_ready = 1'b0;
        wd.in_valid  = 1'b0;
        wd.in_a      = '0;
        wd.in_b      = '0;
        wd.in_c      = '0;
        wd.res_ready = 1'b0;

        step();
        step();
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        check("rst mul_rst", 64'(bus.mul_rst), 64'd0);
        check("rst mul_en", 64'(bus.mul_en), 64'd0);
        check("rst res_valid", 64'(bus.res_valid), 64'd0);
        check("rst res_z", 64'(bus.res_z), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 6; i++) begin
            run_main(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].z, vecs[i].cyc, 1'b0, vecs[i].nm);
        end

        // ov in the first RUN cycle must be ignored; the next ov at RUN cycle 6 ends the run.
        mode = 2;
        run_main(10'd1, 10'd1, 10'd1, 30'd6, 30'd6, 1'b0, "early_ov");
        mode = 0;

        // Watchdog instance with ov stuck low.
        wd.in_a     = 10'd9;
        wd.in_b     = 10'd9;
        wd.in_c     = 10'd9;
        wd.in_valid = 1'b1;
        step();
        wd.in_valid = 1'b0;
        lat = 1;
        while (!wd.res_valid && lat < 200) begin
            step();
            lat++;
        end
        check("wd latency", 64'(lat), 64'd20);
        check("wd res_timeout", 64'(wd.res_timeout), 64'd1);
        check("wd res_cycles", 64'(wd.res_cycles), 64'd16);
        check("wd res_z", 64'(wd.res_z), 64'd77);
        wd.res_ready = 1'b1;
        step();
        wd.res_ready = 1'b0;
        check("wd res_valid_drop", 64'(wd.res_valid), 64'd0);

        // Backpressure: result held 20 cycles while a new triplet waits.
        bus.in_a     = 10'd2;
        bus.in_b     = 10'd1;
        bus.in_c     = 10'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_a = 10'd5;
        lat = 1;
        while (!bus.res_valid && lat < 200) begin
            step();
            lat++;
        end
        check("bp latency", 64'(lat), 64'd7);
        for (int i = 0; i < 20; i++) begin
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
            check("bp res_valid", 64'(bus.res_valid), 64'd1);
            check("bp res_z", 64'(bus.res_z), 64'd2);
            check("bp res_cycles", 64'(bus.res_cycles), 64'd3);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("bp in_ready_after", 64'(bus.in_ready), 64'd1);
        check("bp res_valid_after", 64'(bus.res_valid), 64'd0);
        step();
        bus.in_valid = 1'b0;
        check("bp second_accept mul_rst", 64'(bus.mul_rst), 64'd1);
        check("bp second_accept mul_a", 64'(bus.mul_a), 64'd5);
        lat = 0;
        while (!bus.res_valid && lat < 200) begin
            step();
            lat++;
        end
        check("bp second res_z", 64'(bus.res_z), 64'd5);
        check("bp second res_cycles", 64'(bus.res_cycles), 64'd6);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // Reset in the middle of a RUN.
        bus.in_a     = 10'd3;
        bus.in_b     = 10'd5;
        bus.in_c     = 10'd7;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        check("mid mul_en_before", 64'(bus.mul_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid in_ready", 64'(bus.in_ready), 64'd1);
        check("mid mul_en", 64'(bus.mul_en), 64'd0);
        check("mid mul_rst", 64'(bus.mul_rst), 64'd0);
        check("mid mul_a", 64'(bus.mul_a), 64'd0);
        check("mid res_valid", 64'(bus.res_valid), 64'd0);
        check("mid res_z", 64'(bus.res_z), 64'd0);
        check("mid res_cycles", 64'(bus.res_cycles), 64'd0);
        check("mid res_timeout", 64'(wd.res_timeout), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst res_valid", 64'(bus.res_valid), 64'd0);
        end
        run_main(10'd1, 10'd2, 10'd3, 30'd6, 30'd7, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
